// File: rtl/promedio_frame_rx.sv
// 8N1 UART receiver that packs NBYTES LSB-first bytes into one word.
// Define FRAME_TIMEOUT_EN to drop partial frames after an idle gap.
module promedio_frame_rx #(
  parameter int CLK_FREQ     = 10000,
  parameter int BAUD_RATE    = 1000,
  parameter int WIDTH        = 24,
  parameter int TIMEOUT_BITS = 30
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             rx,
  output logic [WIDTH-1:0] data,
  output logic             data_valid,
  output logic             frame_err,
  output logic [1:0]       byte_idx
);

  localparam int CPB    = CLK_FREQ / BAUD_RATE;
  localparam int NBYTES = WIDTH / 8;
  localparam int CW     = $clog2(CPB + 1);

  localparam logic [CW-1:0] HALF = CW'(CPB / 2 - 1);
  localparam logic [CW-1:0] FULL = CW'(CPB - 1);
  localparam logic [1:0]    LAST = 2'(NBYTES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_WAIT
  } state_t;

  state_t           state_q, state_d;
  logic             rx_meta_q;
  logic             rx_s_q;
  logic             rx_prev_q;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic [WIDTH-1:0] stage_q, stage_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             dv_q, dv_d;
  logic             ferr_q, ferr_d;
  logic [1:0]       idx_q, idx_d;
  logic             start_edge;
  logic             accept;

`ifdef FRAME_TIMEOUT_EN
  localparam int TLIM = TIMEOUT_BITS * CPB;
  localparam int TW   = $clog2(TLIM + 1);
  logic [TW-1:0] tmo_q, tmo_d;
`endif

  assign start_edge = rx_prev_q & ~rx_s_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    stage_d = stage_q;
    data_d  = data_q;
    idx_d   = idx_q;
    dv_d    = 1'b0;
    ferr_d  = 1'b0;
    accept  = 1'b0;
`ifdef FRAME_TIMEOUT_EN
    tmo_d   = tmo_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (start_edge) begin
          cnt_d   = HALF;
          state_d = S_START;
        end
      end
      S_START: begin
        if (cnt_q == '0) begin
          if (!rx_s_q) begin
            cnt_d   = FULL;
            bit_d   = '0;
            state_d = S_DATA;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_DATA: begin
        if (cnt_q == '0) begin
          shift_d = {rx_s_q, shift_q[7:1]};
          cnt_d   = FULL;
          if (bit_q == 3'd7) begin
            state_d = S_STOP;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_STOP: begin
        if (cnt_q == '0) begin
          if (rx_s_q) begin
            accept  = 1'b1;
            state_d = S_IDLE;
          end else begin
            ferr_d  = 1'b1;
            idx_d   = '0;
            state_d = S_WAIT;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_WAIT: begin
        if (rx_s_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (accept) begin
      for (int k = 0; k < NBYTES; k++) begin
        if (idx_q == 2'(k)) stage_d[8*k +: 8] = shift_q;
      end
      if (idx_q == LAST) begin
        data_d = stage_d;
        dv_d   = 1'b1;
        idx_d  = '0;
      end else begin
        idx_d = idx_q + 1'b1;
      end
    end

`ifdef FRAME_TIMEOUT_EN
    // Counts only while idle between bytes of a started frame.
    if (accept || start_edge || idx_q == '0) begin
      tmo_d = '0;
    end else if (state_q == S_IDLE) begin
      if (tmo_q == TW'(TLIM - 1)) begin
        tmo_d   = '0;
        ferr_d  = 1'b1;
        idx_d   = '0;
        stage_d = '0;
      end else begin
        tmo_d = tmo_q + 1'b1;
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      rx_prev_q <= 1'b1;
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      stage_q   <= '0;
      data_q    <= '0;
      dv_q      <= 1'b0;
      ferr_q    <= 1'b0;
      idx_q     <= '0;
`ifdef FRAME_TIMEOUT_EN
      tmo_q     <= '0;
`endif
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
      rx_prev_q <= rx_s_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      stage_q   <= stage_d;
      data_q    <= data_d;
      dv_q      <= dv_d;
      ferr_q    <= ferr_d;
      idx_q     <= idx_d;
`ifdef FRAME_TIMEOUT_EN
      tmo_q     <= tmo_d;
`endif
    end
  end

  assign data       = data_q;
  assign data_valid = dv_q;
  assign frame_err  = ferr_q;
  assign byte_idx   = idx_q;

endmodule

// File: doc/promedio_frame_rx.md
# promedio_frame_rx

Host-side receiver for the sensor's averaged-count UART stream. It deserializes 8N1 UART bytes on `rx` and reassembles each 3-byte, LSB-first average frame into one 24-bit word with a single-cycle valid strobe. It is the reading end of the link that transmits `promedio[7:0]`, then `[15:8]`, then `[23:16]`. It is instantiated in the FPGA/bench host and the loopback test top, on the same `clk` as the sensor's UART.

## Interface
- `CLK_FREQ`, 10000: clock frequency in Hz.
- `BAUD_RATE`, 1000: bit rate. `CLKS_PER_BIT = CLK_FREQ/BAUD_RATE`, which must be ≥4 (default 10).
- `WIDTH`, 24: assembled word width. Must be a multiple of 8, so `NBYTES = WIDTH/8`.
- `TIMEOUT_BITS`, 30: inter-byte gap limit, in bit times. Used only with `FRAME_TIMEOUT_EN`.

Ports:
- `clk` input 1: single clock, rising edge.
- `reset` input 1: synchronous, active-low. Reset occurs when `reset==0` at a `clk` edge.
- `rx` input 1: UART line, idle high, asynchronous to `clk`.
- `data` output WIDTH: last complete frame. Held until the next frame completes.
- `data_valid` output 1: 1-cycle pulse when `data` updates.
- `frame_err` output 1: 1-cycle pulse on a bad stop bit or a timeout.
- `byte_idx` output 2: index of the next expected byte in the frame, 0..NBYTES-1.

## Operation
- **Synchronizer:** `rx` passes through a 2-flop synchronizer, giving `rx_s`. The synchronizer flops reset to 1.
- **FSM states:** IDLE, START, DATA, STOP, WAIT_IDLE.
  - **IDLE:** a falling edge on `rx_s` (previous 1, current 0) loads the bit counter with `CLKS_PER_BIT/2 - 1` and moves to START.
  - **START:** when the counter reaches 0, sample `rx_s`.
    - If 0: go to DATA with the counter at `CLKS_PER_BIT-1` and bit index 0.
    - If 1: this is a glitch. Return to IDLE; no error is flagged.
  - **DATA:** every `CLKS_PER_BIT` clocks, sample one bit, LSB first, into the shift register. After bit 7, go to STOP.
  - **STOP:** after `CLKS_PER_BIT` clocks, sample `rx_s`.
    - If 1: the byte is accepted. Go to IDLE.
    - If 0: pulse `frame_err`, discard the byte, set `byte_idx` to 0, and go to WAIT_IDLE.
  - **WAIT_IDLE:** stay until `rx_s==1`, then go to IDLE. This prevents re-triggering on a break or stuck-low line.
- **Assembler:**
  - An accepted byte is written to lane `byte_idx` of the staging register (`lane k = bits [8k+7:8k]`).
  - If `byte_idx < NBYTES-1`, `byte_idx` increments.
  - Otherwise, the staging register (including the new byte) is copied to `data`, `data_valid` pulses, and `byte_idx` wraps to 0.
- `data` changes only on `data_valid`. Partial frames never reach `data`.
- `frame_err` and `data_valid` are never asserted in the same cycle.

## Timing
- **Reset values:** `data=0`, `data_valid=0`, `frame_err=0`, `byte_idx=0`, FSM=IDLE, staging register=0, timeout counter=0.
- **Reset mid-byte or mid-frame:** the partial byte or frame is dropped. Reception resumes on the next falling edge after reset is released.
- **Edge-to-byte timing:** measured from the cycle the falling edge is seen on `rx_s`:
  - start sample at +`CLKS_PER_BIT/2`;
  - data bit n sampled at +`CLKS_PER_BIT/2 + (n+1)*CLKS_PER_BIT`;
  - stop sample at +`CLKS_PER_BIT/2 + 9*CLKS_PER_BIT` (default +95).
- **Frame completion:** `data_valid` and `data` update are registered in the cycle after the third byte's stop sample.
- **Input latency:** 2 clocks from `rx` to `rx_s`, so 98 clocks from the `rx` start edge to `data_valid` for the last byte (default).
- **Back-to-back bytes:** a start edge immediately after the stop bit (zero idle) must be received. IDLE is re-entered before the next start edge can appear on `rx_s`.
- **Simultaneous events:** if a byte-accept and a timeout fall in the same cycle, the accept wins and the timeout counter clears.

## Configuration
- **`FRAME_TIMEOUT_EN` defined:**
  - When `byte_idx != 0` and the FSM is in IDLE, a counter increments each clock and clears on any start edge.
  - When it reaches `TIMEOUT_BITS*CLKS_PER_BIT`, `frame_err` pulses, `byte_idx` goes to 0, and the staging register clears.
  - This resynchronizes the host after a dropped byte.
- **`FRAME_TIMEOUT_EN` undefined:** no counter logic exists. A partial frame waits indefinitely, and `frame_err` signals only stop-bit errors.

## Test plan
- **Single frame:** defaults; send bytes 0x34, 0x12, 0xAB with 1 idle bit between them -> exactly one `data_valid` with `data=0xAB1234`, and `byte_idx` sequence 0→1→2→0.
- **Bad stop bit:** send byte 0x55 with stop bit 0, then hold `rx` low for 20 bit times -> one `frame_err` pulse; no receive activity until `rx` returns high; `byte_idx=0`; `data` unchanged.
- **Start-bit glitch:** a 2-clock low pulse on idle `rx` -> no `frame_err`, no `data_valid`, FSM back in IDLE.
- **Reset mid-frame:** after 2 bytes, hold `reset=0` for 1 clock, then send 0x01, 0x02, 0x03 -> `data=0x030201`, and exactly one `data_valid`.
- **Back-to-back frames:** two frames with zero inter-byte idle (0xFFFFFF, then 0x000000) -> two `data_valid` pulses, 30 bit times apart, with the correct values.
- **Timeout (`FRAME_TIMEOUT_EN`):** send 1 byte, idle 31 bit times, then send a full frame 0x0A0B0C -> `frame_err` at exactly 300 clocks of idle, then `data=0x0A0B0C`. Without the macro, the same stimulus yields `data=0x0B0C<first byte>` and no `frame_err`.
